sad_row_reduce_min: RTL

- EX4-stage consumer of the 16 per-lane absolute differences latched by the EX3/EX4 pipeline register for the custom SAD instruction.
- Reduces each 16-lane row to a row sum through a 2-stage adder tree and accumulates ROWS rows into one window SAD.
- Tracks the running minimum window SAD and its (x,y) position across a frame, handing results to the EX4/WB side.

---
 rtl/sad_row_reduce_min.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sad_row_reduce_min.sv
// SAD row reduction for EX4: 16-lane saturating adder tree, window accumulator and frame minimum tracker.
// Optional early window abort is enabled by defining SAD_EARLY_EXIT_EN.
module sad_row_reduce_min #(
   parameter int DATA_W = 32,
   parameter int ROWS   = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [16*DATA_W-1:0] diff_bus,
   input  logic [DATA_W-1:0]    win_x,
   input  logic [DATA_W-1:0]    win_y,
   output logic [DATA_W-1:0]    min_sad,
   output logic [DATA_W-1:0]    best_x,
   output logic [DATA_W-1:0]    best_y,
   output logic                 result_valid,
   output logic                 busy,
   output logic                 early_abort
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [DATA_W-1:0] SAT_MAX = '1;
   localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(ROWS - 1);

   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DATA_W] ? SAT_MAX : s[DATA_W-1:0];
   endfunction

   logic [DATA_W-1:0] lane [16];
   logic [DATA_W-1:0] part_c [4];
   logic [CNT_W-1:0]  row_cnt, cnt_base, cnt_next;
   logic              row_first, row_last;

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         lane[k] = diff_bus[k*DATA_W +: DATA_W];
      end
      for (int j = 0; j < 4; j++) begin
         part_c[j] = sat_add(sat_add(lane[4*j], lane[4*j+1]),
                             sat_add(lane[4*j+2], lane[4*j+3]));
      end
   end

   // A row presented together with start is row 0 of the new frame.
   always_comb begin
      cnt_base  = start ? '0 : row_cnt;
      row_first = (cnt_base == '0);
      row_last  = (cnt_base == LAST_ROW);
      cnt_next  = cnt_base;
      if (in_valid) begin
         cnt_next = row_last ? '0 : cnt_base + 1'b1;
      end
   end

   // ---- Stage A: four 4-lane partial sums
   logic [DATA_W-1:0] part_p0 [4];
   logic [DATA_W-1:0] x_p0, y_p0;
   logic              vld_p0, first_p0, last_p0;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         row_cnt  <= '0;
         vld_p0   <= 1'b0;
         first_p0 <= 1'b0;
         last_p0  <= 1'b0;
      end else begin
         row_cnt  <= cnt_next;
         vld_p0   <= in_valid;
         first_p0 <= row_first;
         last_p0  <= row_last;
      end
   end

   always_ff @(posedge Clk) begin
      if (in_valid) begin
         part_p0 <= part_c;
         if (row_last) begin
            x_p0 <= win_x;
            y_p0 <= win_y;
         end
      end
   end

   // ---- Stage B: row sum and window accumulation
   logic [DATA_W-1:0] row_sum, acc_sum, acc_next;
   logic [DATA_W-1:0] acc_p1, x_p1, y_p1;
   logic              vld_p1, last_p1, dead_p1, dead_next;

   always_comb begin
      row_sum = sat_add(sat_add(part_p0[0], part_p0[1]), sat_add(part_p0[2], part_p0[3]));
      acc_sum = first_p0 ? row_sum : sat_add(acc_p1, row_sum);
`ifdef SAD_EARLY_EXIT_EN
      begin
         logic dead_in;
         dead_in   = first_p0 ? 1'b0 : dead_p1;
         acc_next  = dead_in ? acc_p1 : acc_sum;
         dead_next = dead_in | (!last_p0 && (acc_sum >= min_sad));
      end
`else
      acc_next  = acc_sum;
      dead_next = 1'b0;
`endif
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         dead_p1 <= 1'b0;
         acc_p1  <= '0;
      end else if (start) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         dead_p1 <= 1'b0;
      end else begin
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;
         if (vld_p0) begin
            acc_p1  <= acc_next;
            dead_p1 <= dead_next;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (vld_p0 && last_p0) begin
         x_p1 <= x_p0;
         y_p1 <= y_p0;
      end
   end

   // ---- Stage C: compare completed window against the frame minimum
   logic win_done;
   logic ea_p2;
   assign win_done = vld_p1 & last_p1;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         min_sad      <= SAT_MAX;
         best_x       <= '0;
         best_y       <= '0;
         result_valid <= 1'b0;
         ea_p2        <= 1'b0;
      end else if (start) begin
         min_sad      <= SAT_MAX;
         best_x       <= '0;
         best_y       <= '0;
         result_valid <= 1'b0;
         ea_p2        <= 1'b0;
      end else begin
         result_valid <= win_done;
         ea_p2        <= win_done & dead_p1;
         // Strict less-than: ties keep the earlier window.
         if (win_done && !dead_p1 && (acc_p1 < min_sad)) begin
            min_sad <= acc_p1;
            best_x  <= x_p1;
            best_y  <= y_p1;
         end
      end
   end

`ifdef SAD_EARLY_EXIT_EN
   assign early_abort = ea_p2;
`else
   assign early_abort = 1'b0;
`endif

   assign busy = vld_p0 | vld_p1;

endmodule
